// File: rtl/serial_fifo_uart.sv
// rtl/serial_fifo_uart.sv - full-duplex UART with TX/RX circular FIFOs
// Valid/ready byte side, 2-FF synchronised RXD, mid-bit sampling, sticky error flags, loopback.
module serial_fifo_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 RXD,
  output logic                 TXD,
  input  logic                 LOOPBACK,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 RX_OVERRUN,
  output logic                 RX_FRAME_ERR,
  input  logic                 CLR_ERR
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_q, tx_rd_q;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop;

  assign TX_READY = (tx_cnt_q != FULL);
  assign tx_push  = TX_VALID && TX_READY;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr_q] <= TX_DATA;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // ---------------- TX FSM ----------------
  state_e               tx_state_q, tx_state_d;
  logic [TW-1:0]        tx_tick_q, tx_tick_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_drive, txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    tx_drive   = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_cnt_q != '0) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem[tx_rd_q];
          tx_tick_d  = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_drive = 1'b0;
        if (tx_tick_q == T_LAST) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_tick_d = tx_tick_q + TW'(1);
        end
      end
      S_DATA: begin
        tx_drive = tx_sh_q[0];
        if (tx_tick_q == T_LAST) begin
          tx_tick_d = '0;
          tx_sh_d   = tx_sh_q >> 1;
          if (tx_bit_q == B_LAST) tx_state_d = S_STOP;
          else                    tx_bit_d   = tx_bit_q + BW'(1);
        end else begin
          tx_tick_d = tx_tick_q + TW'(1);
        end
      end
      default: begin
        // Chain straight into the next start bit when more data is queued.
        if (tx_tick_q == T_LAST) begin
          tx_tick_d = '0;
          if (tx_cnt_q != '0) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem[tx_rd_q];
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_tick_d = tx_tick_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= tx_drive;
    end
  end

  assign TXD = txd_q;

  // ---------------- RX input ----------------
  logic rxd_s1_q, rxd_s2_q, rx_in;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= RXD;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  assign rx_in = LOOPBACK ? txd_q : rxd_s2_q;

  // ---------------- RX FIFO signals ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_q, rx_rd_q, rx_rd_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_push, rx_pop, rx_ovr_set, rx_fe_set;
  logic                 ovr_q, fe_q;

  assign RX_VALID = (rx_cnt_q != '0);
  assign rx_pop   = RX_VALID && RX_READY;

  // ---------------- RX FSM ----------------
  state_e               rx_state_q, rx_state_d;
  logic [TW-1:0]        rx_tick_q, rx_tick_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    rx_fe_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_in) begin
          rx_tick_d  = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_tick_q == T_HALF) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_in ? S_IDLE : S_DATA;
        end else begin
          rx_tick_d = rx_tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (rx_tick_q == T_LAST) begin
          rx_tick_d = '0;
          rx_sh_d   = {rx_in, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == B_LAST) rx_state_d = S_STOP;
          else                    rx_bit_d   = rx_bit_q + BW'(1);
        end else begin
          rx_tick_d = rx_tick_q + TW'(1);
        end
      end
      default: begin
        // Leave at the stop-bit centre so the next start edge is not missed.
        if (rx_tick_q == T_LAST) begin
          rx_tick_d  = '0;
          rx_state_d = S_IDLE;
          if (!rx_in)                            rx_fe_set  = 1'b1;
          else if (rx_cnt_q != FULL || rx_pop)   rx_push    = 1'b1;
          else                                   rx_ovr_set = 1'b1;
        end else begin
          rx_tick_d = rx_tick_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- RX FIFO ----------------
  always_comb begin
    rx_rd_d  = rx_pop ? rx_rd_q + AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
  end

  // The new head may be the entry being written this very cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
      rx_data_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      if (rx_cnt_d != '0)
        rx_data_q <= (rx_push && rx_rd_d == rx_wr_q) ? rx_sh_q : rx_mem[rx_rd_d];
    end
  end

  assign RX_DATA = rx_data_q;

  // ---------------- sticky flags ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      if (rx_ovr_set)   ovr_q <= 1'b1;
      else if (CLR_ERR) ovr_q <= 1'b0;
      if (rx_fe_set)    fe_q  <= 1'b1;
      else if (CLR_ERR) fe_q  <= 1'b0;
    end
  end

  assign RX_OVERRUN   = ovr_q;
  assign RX_FRAME_ERR = fe_q;

endmodule

// File: tb/tb_serial_fifo_uart.sv
// tb/tb_serial_fifo_uart.sv - scoreboard bench for serial_fifo_uart
// Expected bytes queue per direction; line decoder and RX consumer pop and compare.
module tb_serial_fifo_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       RXD = 1'b1;
  logic       TXD;
  logic       LOOPBACK = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY = 1'b1;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;
  logic       CLR_ERR = 1'b0;

  serial_fifo_uart #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .RXD(RXD), .TXD(TXD), .LOOPBACK(LOOPBACK),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .RX_OVERRUN(RX_OVERRUN), .RX_FRAME_ERR(RX_FRAME_ERR), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         push_cyc = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         tx_starts[$];
  bit         exp_ovr = 0;
  bit         exp_fe = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Serial line decoder: samples each bit near its centre.
  logic [7:0] tx_got, tx_want;
  logic       tx_stop, tx_start_lvl;
  bit         tx_ok;
  int         tx_st;
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTN && TXD === 1'b0) begin
        tx_ok = 1;
        tx_st = cyc;
        repeat (2) begin @(negedge CLK); if (!RSTN) tx_ok = 0; end
        tx_start_lvl = TXD;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge CLK); if (!RSTN) tx_ok = 0; end
          tx_got[i] = TXD;
        end
        repeat (CPB) begin @(negedge CLK); if (!RSTN) tx_ok = 0; end
        tx_stop = TXD;
        if (tx_ok) begin
          tx_starts.push_back(tx_st);
          if (tx_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected_frame: actual=%0h required=none", tx_got);
          end else begin
            tx_want = tx_exp.pop_front();
            chk("tx_start_bit", tx_start_lvl, 0);
            chk("tx_byte", tx_got, tx_want);
            chk("tx_stop_bit", tx_stop, 1);
          end
        end
      end
    end
  end

  // Byte consumer: every RX handshake must match the next expected byte.
  logic [7:0] rx_want;
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTN && RX_VALID && RX_READY) begin
        if (rx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected_byte: actual=%0h required=none", RX_DATA);
        end else begin
          rx_want = rx_exp.pop_front();
          chk("rx_byte", RX_DATA, rx_want);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    TX_DATA  = b;
    TX_VALID = 1'b1;
    while (!TX_READY && guard < 2000) begin @(posedge CLK); #1; guard++; end
    if (guard >= 2000) chk("push_timeout", guard, 0);
    @(posedge CLK); #1;
    TX_VALID = 1'b0;
    push_cyc = cyc;
    tx_exp.push_back(b);
    if (LOOPBACK) rx_exp.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (!stop)                                      exp_fe = 1;
    else if (!RX_READY && rx_exp.size() >= DEPTH)   exp_ovr = 1;
    else                                            rx_exp.push_back(b);
    RXD = 1'b0;
    repeat (CPB) @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(posedge CLK); #1;
    end
    RXD = stop;
    repeat (CPB) @(posedge CLK); #1;
    RXD = 1'b1;
    repeat (8) @(posedge CLK); #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < budget) begin
      @(posedge CLK); n++;
    end
    #1;
    chk("drain_in_budget", int'(n < budget), 1);
    repeat (8) @(posedge CLK); #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overrun"}, RX_OVERRUN, exp_ovr);
    chk({tag, "_frame_err"}, RX_FRAME_ERR, exp_fe);
  endtask

  task automatic clear_err();
    CLR_ERR = 1'b1;
    @(posedge CLK); #1;
    CLR_ERR = 1'b0;
    exp_ovr = 0;
    exp_fe  = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK); #1;
    chk("reset_txd", TXD, 1);
    chk("reset_tx_ready", TX_READY, 1);
    chk("reset_rx_valid", RX_VALID, 0);
    chk("reset_rx_data", RX_DATA, 0);
    check_flags("reset");
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // Single frame from idle: start bit two cycles after acceptance.
    push_byte(8'hA5);
    wait_drain(200);
    chk("t1_frames", tx_starts.size(), 1);
    if (tx_starts.size() == 1) chk("t1_latency", tx_starts[0] - push_cyc, 2);
    tx_starts.delete();

    // Idle transmitter absorbs one byte into the shifter, so DEPTH+1 are accepted back to back.
    for (int k = 1; k <= 5; k++) begin
      chk("t2_ready_before_push", TX_READY, 1);
      push_byte(8'(k * 8'h11));
    end
    chk("t2_ready_full", TX_READY, 0);
    wait_drain(400);
    chk("t2_frames", tx_starts.size(), 5);
    for (int k = 1; k < tx_starts.size(); k++)
      chk("t2_frame_spacing", tx_starts[k] - tx_starts[k-1], 40);
    tx_starts.delete();

    // Received byte held at RX head until consumed.
    RX_READY = 1'b0;
    send_frame(8'h3C, 1'b1);
    chk("t3_rx_valid", RX_VALID, 1);
    chk("t3_rx_data", RX_DATA, 8'h3C);
    RX_READY = 1'b1;
    wait_drain(50);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    RX_READY = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    chk("t4_rx_valid", RX_VALID, 1);
    check_flags("t4_after");
    clear_err();
    check_flags("t4_cleared");
    RX_READY = 1'b1;
    wait_drain(50);

    // Bad stop bit, then a one-cycle glitch.
    send_frame(8'h7E, 1'b0);
    check_flags("t5_stop_low");
    chk("t5_rx_valid", RX_VALID, 0);
    clear_err();
    RXD = 1'b0;
    @(posedge CLK); #1;
    RXD = 1'b1;
    repeat (30) @(posedge CLK); #1;
    chk("t5_glitch_rx_valid", RX_VALID, 0);
    check_flags("t5_glitch");

    // Random receive traffic with random idle gaps.
    for (int k = 0; k < 6; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 10)) @(posedge CLK);
      #1;
    end
    wait_drain(100);
    check_flags("rand_rx");

    // Loopback: transmitted bytes come back in order.
    LOOPBACK = 1'b1;
    @(posedge CLK); #1;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h81);
    wait_drain(400);
    for (int k = 0; k < 6; k++) begin
      push_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 30)) @(posedge CLK);
      #1;
    end
    wait_drain(800);
    check_flags("t6_loop");

    // Reset in the middle of a loopback frame.
    push_byte(8'h96);
    push_byte(8'h69);
    repeat (15) @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    tx_exp.delete();
    rx_exp.delete();
    exp_ovr = 0;
    exp_fe  = 0;
    chk("t6_rst_txd", TXD, 1);
    chk("t6_rst_tx_ready", TX_READY, 1);
    chk("t6_rst_rx_valid", RX_VALID, 0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    repeat (200) @(posedge CLK); #1;
    chk("t6_post_rx_valid", RX_VALID, 0);
    chk("t6_post_txd", TXD, 1);
    check_flags("t6_post");
    push_byte(8'h5A);
    wait_drain(200);

    chk("end_tx_queue_empty", tx_exp.size(), 0);
    chk("end_rx_queue_empty", rx_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
